// File: rtl/vdp_super_palette.sv
// vdp_super_palette: 256x24 CPU-loaded RGB palette with a 1-cycle pixel lookup.
// Define SUPER_PALETTE_READBACK_EN to enable CPU readback through the data port.
module vdp_super_palette (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_vdp_super,
  input  logic       i_cpu_wr,
  input  logic       i_cpu_rd,
  input  logic       i_cpu_port,
  input  logic [7:0] i_cpu_din,
  output logic [7:0] o_cpu_dout,
  input  logic [7:0] i_pixel_addr,
  output logic [7:0] o_pixel_r,
  output logic [7:0] o_pixel_g,
  output logic [7:0] o_pixel_b
);
  localparam logic [1:0] PH_R = 2'd0;
  localparam logic [1:0] PH_G = 2'd1;
  localparam logic [1:0] PH_B = 2'd2;
  typedef logic [23:0] ram_t [256];
  function automatic ram_t ramp();
    ram_t m;
    for (int k = 0; k < 256; k++) m[k] = {3{8'(k)}};
    return m;
  endfunction
  ram_t r_ram = ramp();
  logic [1:0]  r_phase;
  logic [7:0]  r_index;
  logic [7:0]  r_r;
  logic [7:0]  r_g;
  logic [23:0] r_pix;
  logic        w_data_wr;
  logic        w_data_rd;
  logic        w_step;
  logic        w_commit;
  logic [1:0]  w_ph_nxt;
  assign w_data_wr = i_cpu_wr & i_cpu_port;
  assign w_step    = w_data_wr | w_data_rd;
  assign w_commit  = w_data_wr & (r_phase == PH_B);
  assign w_ph_nxt  = (r_phase == PH_R) ? PH_G : (r_phase == PH_G) ? PH_B : PH_R;
  assign {o_pixel_r, o_pixel_g, o_pixel_b} = r_pix;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= PH_R;
      r_index <= '0;
      r_r     <= '0;
      r_g     <= '0;
      r_pix   <= '0;
    end else begin
      r_pix <= i_vdp_super ? r_ram[i_pixel_addr] : '0;
      if (i_cpu_wr && !i_cpu_port) begin
        r_index <= i_cpu_din;
        r_phase <= PH_R;
      end else if (w_step) begin
        r_phase <= w_ph_nxt;
        if (r_phase == PH_B) r_index <= r_index + 8'd1;
        if (w_data_wr && r_phase == PH_R) r_r <= i_cpu_din;
        if (w_data_wr && r_phase == PH_G) r_g <= i_cpu_din;
      end
    end
  end
  // Nonblocking write gives read-before-write against the pixel port on a shared edge.
  always_ff @(posedge clk) begin
    if (w_commit) r_ram[r_index] <= {r_r, r_g, i_cpu_din};
  end
`ifdef SUPER_PALETTE_READBACK_EN
  logic [7:0]  r_dout;
  logic [23:0] w_entry;
  logic [7:0]  w_sel;
  assign w_data_rd  = i_cpu_rd & ~i_cpu_wr & i_cpu_port;
  assign w_entry    = r_ram[r_index];
  assign w_sel      = (r_phase == PH_R) ? w_entry[23:16] : (r_phase == PH_G) ? w_entry[15:8] : w_entry[7:0];
  assign o_cpu_dout = r_dout;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_dout <= '0;
    else if (w_data_rd) r_dout <= w_sel;
  end
`else
  logic w_unused;
  assign w_data_rd  = 1'b0;
  assign w_unused   = i_cpu_rd;
  assign o_cpu_dout = '0;
`endif
endmodule

// File: tb/tb_vdp_super_palette.sv
// tb_vdp_super_palette: vector table plus hand sequences for the super-res palette.
module tb_vdp_super_palette;
  logic       clk = 1'b0;
  logic       reset;
  logic       i_vdp_super, i_cpu_wr, i_cpu_rd, i_cpu_port;
  logic [7:0] i_cpu_din, i_pixel_addr;
  logic [7:0] o_cpu_dout, o_pixel_r, o_pixel_g, o_pixel_b;
  int total = 0;
  int bad = 0;
  logic [23:0] sb[$];
  logic [23:0] ref_mem [256];
  typedef struct {
    logic wr, rd, port;
    logic [7:0] din;
    logic sup;
    logic [7:0] addr;
    logic [23:0] exp;
  } vec_t;
  vec_t tbl[$];

  vdp_super_palette dut (
    .clk(clk), .reset(reset), .i_vdp_super(i_vdp_super), .i_cpu_wr(i_cpu_wr),
    .i_cpu_rd(i_cpu_rd), .i_cpu_port(i_cpu_port), .i_cpu_din(i_cpu_din),
    .o_cpu_dout(o_cpu_dout), .i_pixel_addr(i_pixel_addr),
    .o_pixel_r(o_pixel_r), .o_pixel_g(o_pixel_g), .o_pixel_b(o_pixel_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [23:0] got, input logic [23:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic step(input logic wr, input logic rd, input logic port, input logic [7:0] din,
                      input logic sup, input logic [7:0] addr, input logic [23:0] exp, input string nm);
    @(negedge clk);
    i_cpu_wr = wr; i_cpu_rd = rd; i_cpu_port = port; i_cpu_din = din;
    i_vdp_super = sup; i_pixel_addr = addr;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    i_cpu_wr = 1'b0; i_cpu_rd = 1'b0;
    chk(nm, {o_pixel_r, o_pixel_g, o_pixel_b}, sb.pop_front());
`ifndef SUPER_PALETTE_READBACK_EN
    chk({nm, "_dout"}, {16'h0, o_cpu_dout}, 24'h0);
`endif
  endtask

  initial begin
    for (int k = 0; k < 256; k++) ref_mem[k] = {3{8'(k)}};
    tbl.push_back(vec_t'{1, 0, 0, 8'h10, 1, 8'h40, 24'h404040});
    tbl.push_back(vec_t'{1, 0, 1, 8'h11, 1, 8'h10, 24'h101010});
    tbl.push_back(vec_t'{1, 0, 1, 8'h22, 1, 8'h10, 24'h101010});
    tbl.push_back(vec_t'{1, 0, 1, 8'h33, 1, 8'h10, 24'h101010});
    tbl.push_back(vec_t'{1, 0, 1, 8'hAA, 1, 8'h10, 24'h112233});
    tbl.push_back(vec_t'{1, 1, 1, 8'hBB, 1, 8'h11, 24'h111111});
    tbl.push_back(vec_t'{1, 0, 1, 8'hCC, 1, 8'h11, 24'h111111});
    tbl.push_back(vec_t'{0, 0, 0, 8'h00, 1, 8'h11, 24'hAABBCC});
    tbl.push_back(vec_t'{1, 0, 0, 8'hFF, 1, 8'hFF, 24'hFFFFFF});
    tbl.push_back(vec_t'{1, 0, 1, 8'h01, 1, 8'h00, 24'h000000});
    tbl.push_back(vec_t'{1, 0, 1, 8'h02, 1, 8'h00, 24'h000000});
    tbl.push_back(vec_t'{1, 0, 1, 8'h03, 1, 8'hFF, 24'hFFFFFF});
    tbl.push_back(vec_t'{1, 0, 1, 8'h44, 1, 8'hFF, 24'h010203});
    tbl.push_back(vec_t'{1, 0, 1, 8'h55, 1, 8'h00, 24'h000000});
    tbl.push_back(vec_t'{1, 0, 1, 8'h66, 1, 8'h00, 24'h000000});
    tbl.push_back(vec_t'{0, 0, 0, 8'h00, 1, 8'h00, 24'h445566});
    tbl.push_back(vec_t'{1, 0, 0, 8'h05, 1, 8'h05, 24'h050505});
    tbl.push_back(vec_t'{1, 0, 1, 8'h01, 1, 8'h06, 24'h060606});
    tbl.push_back(vec_t'{1, 0, 1, 8'h02, 1, 8'h06, 24'h060606});
    tbl.push_back(vec_t'{1, 0, 0, 8'h06, 1, 8'h06, 24'h060606});
    tbl.push_back(vec_t'{1, 0, 1, 8'h0A, 1, 8'h06, 24'h060606});
    tbl.push_back(vec_t'{1, 0, 1, 8'h0B, 1, 8'h06, 24'h060606});
    tbl.push_back(vec_t'{1, 0, 1, 8'h0C, 1, 8'h06, 24'h060606});
    tbl.push_back(vec_t'{0, 0, 0, 8'h00, 1, 8'h05, 24'h050505});
    tbl.push_back(vec_t'{0, 0, 0, 8'h00, 1, 8'h06, 24'h0A0B0C});
    tbl.push_back(vec_t'{1, 0, 0, 8'h20, 1, 8'h20, 24'h202020});
    tbl.push_back(vec_t'{1, 0, 1, 8'h99, 1, 8'h20, 24'h202020});
    tbl.push_back(vec_t'{1, 0, 1, 8'h88, 1, 8'h20, 24'h202020});
    tbl.push_back(vec_t'{1, 0, 1, 8'h77, 1, 8'h20, 24'h202020});
    tbl.push_back(vec_t'{0, 0, 0, 8'h00, 1, 8'h20, 24'h998877});
    tbl.push_back(vec_t'{0, 0, 0, 8'h00, 0, 8'h20, 24'h000000});
    tbl.push_back(vec_t'{0, 0, 0, 8'h00, 1, 8'h20, 24'h998877});

    reset = 1'b1; i_vdp_super = 1'b1; i_cpu_wr = 1'b0; i_cpu_rd = 1'b0;
    i_cpu_port = 1'b0; i_cpu_din = 8'h00; i_pixel_addr = 8'h40;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pixel", {o_pixel_r, o_pixel_g, o_pixel_b}, 24'h0);
    chk("reset_dout", {16'h0, o_cpu_dout}, 24'h0);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) step(tbl[i].wr, tbl[i].rd, tbl[i].port, tbl[i].din, tbl[i].sup, tbl[i].addr, tbl[i].exp, $sformatf("vec%0d", i));

    // Reset after R and G abandons entry 0x30 and restarts at index 0.
    step(1, 0, 0, 8'h30, 1, 8'h30, 24'h303030, "abort_idx");
    step(1, 0, 1, 8'h01, 1, 8'h30, 24'h303030, "abort_r");
    step(1, 0, 1, 8'h02, 1, 8'h30, 24'h303030, "abort_g");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_mid", {o_pixel_r, o_pixel_g, o_pixel_b}, 24'h0);
    @(negedge clk);
    reset = 1'b0;
    step(1, 0, 1, 8'h0A, 1, 8'h00, 24'h445566, "post_rst_r");
    step(1, 0, 1, 8'h0B, 1, 8'h00, 24'h445566, "post_rst_g");
    step(1, 0, 1, 8'h0C, 1, 8'h00, 24'h445566, "post_rst_b");
    step(0, 0, 0, 8'h00, 1, 8'h30, 24'h303030, "abort_kept");
    step(0, 0, 0, 8'h00, 1, 8'h00, 24'h0A0B0C, "post_rst_ent");

    ref_mem[8'h10] = 24'h112233; ref_mem[8'h11] = 24'hAABBCC; ref_mem[8'hFF] = 24'h010203;
    ref_mem[8'h00] = 24'h0A0B0C; ref_mem[8'h06] = 24'h0A0B0C; ref_mem[8'h20] = 24'h998877;
    for (int k = 0; k < 256; k++) begin
      logic s;
      s = !(k >= 100 && k <= 102);
      step(0, 0, 0, 8'h00, s, 8'(k), s ? ref_mem[k] : 24'h0, $sformatf("stream%0d", k));
    end

    step(1, 0, 0, 8'h10, 1, 8'h10, 24'h112233, "rb_idx");
    step(0, 1, 1, 8'h00, 1, 8'h10, 24'h112233, "rb_r");
`ifdef SUPER_PALETTE_READBACK_EN
    chk("rb_dout_r", {16'h0, o_cpu_dout}, 24'h11);
`endif
    step(0, 1, 1, 8'h00, 1, 8'h10, 24'h112233, "rb_g");
`ifdef SUPER_PALETTE_READBACK_EN
    chk("rb_dout_g", {16'h0, o_cpu_dout}, 24'h22);
`endif
    step(0, 1, 1, 8'h00, 1, 8'h10, 24'h112233, "rb_b");
`ifdef SUPER_PALETTE_READBACK_EN
    chk("rb_dout_b", {16'h0, o_cpu_dout}, 24'h33);
`endif
    step(1, 0, 1, 8'hDE, 1, 8'h10, 24'h112233, "rb_wr_r");
    step(1, 0, 1, 8'hAD, 1, 8'h10, 24'h112233, "rb_wr_g");
    step(1, 0, 1, 8'hBE, 1, 8'h10, 24'h112233, "rb_wr_b");
`ifdef SUPER_PALETTE_READBACK_EN
    step(0, 0, 0, 8'h00, 1, 8'h10, 24'h112233, "rb_ent10");
    step(0, 0, 0, 8'h00, 1, 8'h11, 24'hDEADBE, "rb_ent11");
`else
    step(0, 0, 0, 8'h00, 1, 8'h10, 24'hDEADBE, "rb_ent10");
    step(0, 0, 0, 8'h00, 1, 8'h11, 24'hAABBCC, "rb_ent11");
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
